// File: rtl/fpu_interco_pkg.sv
// Shared definitions for the FPU APU interconnect.
// Contents:
//   slot_w()     - index width for a DEPTH-entry reorder buffer
//   apu_tag_t    - APU tag split into {core_id, slot} for the default configuration
//   slot_rec_t   - reorder-slot record {pending, done, data, flags} for the default configuration
package fpu_interco_pkg;

   localparam int unsigned DEF_ID_WIDTH        = 9;
   localparam int unsigned DEF_DATA_WIDTH      = 32;
   localparam int unsigned DEF_FLAGS_OUT_WIDTH = 5;
   localparam int unsigned DEF_DEPTH           = 4;

   function automatic int unsigned slot_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

   localparam int unsigned DEF_SLOT_W = slot_w(DEF_DEPTH);

   typedef struct packed {
      logic [DEF_ID_WIDTH-DEF_SLOT_W-1:0] core_id;
      logic [DEF_SLOT_W-1:0]              slot;
   } apu_tag_t;

   typedef struct packed {
      logic                           pending;
      logic                           done;
      logic [DEF_DATA_WIDTH-1:0]      data;
      logic [DEF_FLAGS_OUT_WIDTH-1:0] flags;
   } slot_rec_t;

endpackage

// File: rtl/apu_rob.sv
// Reorder buffer for APU responses.
// Slots are allocated in issue order, filled by tag in any order, and the
// head slot (rd_ptr) is presented until retired.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   alloc, alloc_idx      mark slot pending (issue)
//   wr_en, wr_idx,
//   wr_data, wr_flags     store a response and mark slot done
//   slot_open             wr_idx slot is pending and not yet done
//   retire                free the head slot and advance rd_ptr
//   head_valid,
//   head_data, head_flags head slot status and contents
module apu_rob
   import fpu_interco_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned FLAGS_OUT_WIDTH = 5,
   parameter int unsigned DEPTH           = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             alloc,
   input  logic [slot_w(DEPTH)-1:0]         alloc_idx,
   input  logic                             wr_en,
   input  logic [slot_w(DEPTH)-1:0]         wr_idx,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   input  logic [FLAGS_OUT_WIDTH-1:0]       wr_flags,
   output logic                             slot_open,
   input  logic                             retire,
   output logic                             head_valid,
   output logic [DATA_WIDTH-1:0]            head_data,
   output logic [FLAGS_OUT_WIDTH-1:0]       head_flags
);

   localparam int unsigned SLOT_W = slot_w(DEPTH);

   logic [DEPTH-1:0]           pending;
   logic [DEPTH-1:0]           done;
   logic [SLOT_W-1:0]          rd_ptr;
   logic [DATA_WIDTH-1:0]      data_q  [DEPTH];
   logic [FLAGS_OUT_WIDTH-1:0] flags_q [DEPTH];

   // Allocation is applied last: it only lands on the retiring slot when the
   // buffer was empty or full, neither of which permits both in one cycle,
   // but letting it win keeps the slot consistent regardless.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending <= '0;
         done    <= '0;
         rd_ptr  <= '0;
      end else begin
         if (retire) begin
            pending[rd_ptr] <= 1'b0;
            done[rd_ptr]    <= 1'b0;
            rd_ptr          <= rd_ptr + SLOT_W'(1);
         end
         if (wr_en) begin
            done[wr_idx] <= 1'b1;
         end
         if (alloc) begin
            pending[alloc_idx] <= 1'b1;
            done[alloc_idx]    <= 1'b0;
         end
      end
   end

   // Payload needs no reset; it is only observed while the slot is done.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_q[wr_idx]  <= wr_data;
         flags_q[wr_idx] <= wr_flags;
      end
   end

   always_comb begin
      slot_open  = pending[wr_idx] & ~done[wr_idx];
      head_valid = pending[rd_ptr] & done[rd_ptr];
      head_data  = data_q[rd_ptr];
      head_flags = flags_q[rd_ptr];
   end

endmodule

// File: rtl/fpu_apu_initiator.sv
// Core-side APU initiator: tags each issued op with {CORE_ID, slot}, accepts
// every response, reorders completions and returns results in issue order.
// Ports:
//   clk, rst_n                               clock, synchronous active-low reset
//   core_req_i/core_gnt_o, core_operands_i,
//   core_op_i, core_flags_i                  core request side (zero-latency pass-through)
//   core_rvalid_o/core_rready_i,
//   core_rdata_o, core_rflags_o              in-order result to the core
//   apu_req_o/apu_gnt_i, apu_ID_o,
//   apu_operands_o, apu_op_o, apu_flags_o    APU request side
//   apu_rready_o, apu_rvalid_i, apu_rdata_i,
//   apu_rflags_i, apu_rID_i                  APU response side (always ready)
//   busy_o                                   any op outstanding or undelivered
//   protocol_err_o                           sticky unexpected-response flag
module fpu_apu_initiator
   import fpu_interco_pkg::*;
#(
   parameter int unsigned ID_WIDTH        = 9,
   parameter int unsigned NB_ARGS         = 2,
   parameter int unsigned OPCODE_WIDTH    = 6,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned FLAGS_IN_WIDTH  = 15,
   parameter int unsigned FLAGS_OUT_WIDTH = 5,
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned CORE_ID         = 0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            core_req_i,
   output logic                            core_gnt_o,
   input  logic [NB_ARGS*DATA_WIDTH-1:0]   core_operands_i,
   input  logic [OPCODE_WIDTH-1:0]         core_op_i,
   input  logic [FLAGS_IN_WIDTH-1:0]       core_flags_i,
   output logic                            core_rvalid_o,
   input  logic                            core_rready_i,
   output logic [DATA_WIDTH-1:0]           core_rdata_o,
   output logic [FLAGS_OUT_WIDTH-1:0]      core_rflags_o,
   output logic                            apu_req_o,
   input  logic                            apu_gnt_i,
   output logic [ID_WIDTH-1:0]             apu_ID_o,
   output logic [NB_ARGS*DATA_WIDTH-1:0]   apu_operands_o,
   output logic [OPCODE_WIDTH-1:0]         apu_op_o,
   output logic [FLAGS_IN_WIDTH-1:0]       apu_flags_o,
   output logic                            apu_rready_o,
   input  logic                            apu_rvalid_i,
   input  logic [DATA_WIDTH-1:0]           apu_rdata_i,
   input  logic [FLAGS_OUT_WIDTH-1:0]      apu_rflags_i,
   input  logic [ID_WIDTH-1:0]             apu_rID_i,
   output logic                            busy_o,
   output logic                            protocol_err_o
);

   localparam int unsigned SLOT_W = slot_w(DEPTH);
   localparam int unsigned TAG_W  = ID_WIDTH - SLOT_W;
   localparam logic [TAG_W-1:0] CORE_TAG = TAG_W'(CORE_ID);

   logic [SLOT_W:0]   count;
   logic [SLOT_W-1:0] wr_ptr;
   logic              credit;
   logic              issue_fire;
   logic              retire;
   logic              slot_open;
   logic              resp_ok;

   always_comb begin
      credit         = count < (SLOT_W+1)'(DEPTH);
      apu_req_o      = core_req_i & credit;
      core_gnt_o     = apu_gnt_i & credit;
      issue_fire     = apu_req_o & apu_gnt_i;
      apu_ID_o       = {CORE_TAG, wr_ptr};
      apu_operands_o = core_operands_i;
      apu_op_o       = core_op_i;
      apu_flags_o    = core_flags_i;
      apu_rready_o   = 1'b1;
      retire         = core_rvalid_o & core_rready_i;
      resp_ok        = apu_rvalid_i & (apu_rID_i[ID_WIDTH-1:SLOT_W] == CORE_TAG) & slot_open;
      busy_o         = count != '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count          <= '0;
         wr_ptr         <= '0;
         protocol_err_o <= 1'b0;
      end else begin
         if (issue_fire) begin
            wr_ptr <= wr_ptr + SLOT_W'(1);
         end
         if (issue_fire && !retire) begin
            count <= count + (SLOT_W+1)'(1);
         end else if (!issue_fire && retire) begin
            count <= count - (SLOT_W+1)'(1);
         end
         // A response for the slot being retired is already done, so it lands here too.
         if (apu_rvalid_i && !resp_ok) begin
            protocol_err_o <= 1'b1;
         end
      end
   end

   apu_rob #(
      .DATA_WIDTH      (DATA_WIDTH),
      .FLAGS_OUT_WIDTH (FLAGS_OUT_WIDTH),
      .DEPTH           (DEPTH)
   ) u_rob (
      .clk        (clk),
      .rst_n      (rst_n),
      .alloc      (issue_fire),
      .alloc_idx  (wr_ptr),
      .wr_en      (resp_ok),
      .wr_idx     (apu_rID_i[SLOT_W-1:0]),
      .wr_data    (apu_rdata_i),
      .wr_flags   (apu_rflags_i),
      .slot_open  (slot_open),
      .retire     (retire),
      .head_valid (core_rvalid_o),
      .head_data  (core_rdata_o),
      .head_flags (core_rflags_o)
   );

endmodule

// File: tb/tb_fpu_apu_initiator.sv
// Testbench for fpu_apu_initiator: directed scenarios with a queue-based
// in-order model checked every cycle, plus literal expectations per scenario.
module tb_fpu_apu_initiator;

   localparam int unsigned ID_WIDTH        = 9;
   localparam int unsigned NB_ARGS         = 2;
   localparam int unsigned OPCODE_WIDTH    = 6;
   localparam int unsigned DATA_WIDTH      = 32;
   localparam int unsigned FLAGS_IN_WIDTH  = 15;
   localparam int unsigned FLAGS_OUT_WIDTH = 5;
   localparam int unsigned DEPTH           = 4;
   localparam int unsigned SLOT_W          = 2;
   localparam int unsigned CORE_ID         = 0;

   logic                          clk = 1'b0;
   logic                          rst_n = 1'b0;
   logic                          core_req_i = 1'b0;
   logic                          core_gnt_o;
   logic [NB_ARGS*DATA_WIDTH-1:0] core_operands_i = '0;
   logic [OPCODE_WIDTH-1:0]       core_op_i = '0;
   logic [FLAGS_IN_WIDTH-1:0]     core_flags_i = '0;
   logic                          core_rvalid_o;
   logic                          core_rready_i = 1'b1;
   logic [DATA_WIDTH-1:0]         core_rdata_o;
   logic [FLAGS_OUT_WIDTH-1:0]    core_rflags_o;
   logic                          apu_req_o;
   logic                          apu_gnt_i = 1'b0;
   logic [ID_WIDTH-1:0]           apu_ID_o;
   logic [NB_ARGS*DATA_WIDTH-1:0] apu_operands_o;
   logic [OPCODE_WIDTH-1:0]       apu_op_o;
   logic [FLAGS_IN_WIDTH-1:0]     apu_flags_o;
   logic                          apu_rready_o;
   logic                          apu_rvalid_i = 1'b0;
   logic [DATA_WIDTH-1:0]         apu_rdata_i = '0;
   logic [FLAGS_OUT_WIDTH-1:0]    apu_rflags_i = '0;
   logic [ID_WIDTH-1:0]           apu_rID_i = '0;
   logic                          busy_o;
   logic                          protocol_err_o;

   always #5 clk = ~clk;

   fpu_apu_initiator #(
      .ID_WIDTH        (ID_WIDTH),
      .NB_ARGS         (NB_ARGS),
      .OPCODE_WIDTH    (OPCODE_WIDTH),
      .DATA_WIDTH      (DATA_WIDTH),
      .FLAGS_IN_WIDTH  (FLAGS_IN_WIDTH),
      .FLAGS_OUT_WIDTH (FLAGS_OUT_WIDTH),
      .DEPTH           (DEPTH),
      .CORE_ID         (CORE_ID)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .core_req_i      (core_req_i),
      .core_gnt_o      (core_gnt_o),
      .core_operands_i (core_operands_i),
      .core_op_i       (core_op_i),
      .core_flags_i    (core_flags_i),
      .core_rvalid_o   (core_rvalid_o),
      .core_rready_i   (core_rready_i),
      .core_rdata_o    (core_rdata_o),
      .core_rflags_o   (core_rflags_o),
      .apu_req_o       (apu_req_o),
      .apu_gnt_i       (apu_gnt_i),
      .apu_ID_o        (apu_ID_o),
      .apu_operands_o  (apu_operands_o),
      .apu_op_o        (apu_op_o),
      .apu_flags_o     (apu_flags_o),
      .apu_rready_o    (apu_rready_o),
      .apu_rvalid_i    (apu_rvalid_i),
      .apu_rdata_i     (apu_rdata_i),
      .apu_rflags_i    (apu_rflags_i),
      .apu_rID_i       (apu_rID_i),
      .busy_o          (busy_o),
      .protocol_err_o  (protocol_err_o)
   );

   int ntests = 0;
   int nfail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: ops in issue order, each remembering its slot and whether its
   // result has arrived. The head is delivered once done.
   typedef struct {
      int unsigned                slot;
      bit                         done;
      logic [DATA_WIDTH-1:0]      data;
      logic [FLAGS_OUT_WIDTH-1:0] flags;
   } op_t;

   op_t         q[$];
   int unsigned issue_cnt = 0;
   bit          m_err = 1'b0;
   bit          model_ok = 1'b0;

   always @(posedge clk) begin
      bit fire;
      bit ret;
      int hit;
      if (!rst_n) begin
         q.delete();
         issue_cnt = 0;
         m_err     = 1'b0;
         model_ok  = 1'b1;
      end else if (model_ok) begin
         fire = core_req_i && apu_gnt_i && (q.size() < DEPTH);
         ret  = (q.size() > 0) && q[0].done && core_rready_i;
         if (apu_rvalid_i) begin
            hit = -1;
            if ((apu_rID_i >> SLOT_W) == CORE_ID) begin
               foreach (q[i]) begin
                  if (q[i].slot == (apu_rID_i % DEPTH) && !q[i].done) hit = i;
               end
            end
            if (hit < 0) begin
               m_err = 1'b1;
            end else begin
               q[hit].done  = 1'b1;
               q[hit].data  = apu_rdata_i;
               q[hit].flags = apu_rflags_i;
            end
         end
         if (ret) void'(q.pop_front());
         if (fire) begin
            q.push_back('{issue_cnt % DEPTH, 1'b0, '0, '0});
            issue_cnt++;
         end
      end
   end

   always @(negedge clk) begin
      bit credit;
      bit exp_rv;
      if (model_ok) begin
         #2;
         credit = q.size() < DEPTH;
         exp_rv = (q.size() > 0) && q[0].done;
         check("apu_req", apu_req_o, core_req_i & credit);
         check("core_gnt", core_gnt_o, apu_gnt_i & credit);
         check("busy", busy_o, q.size() != 0);
         check("perr", protocol_err_o, m_err);
         check("apu_rready", apu_rready_o, 1);
         check("rvalid", core_rvalid_o, exp_rv);
         check("fwd_operands", apu_operands_o, core_operands_i);
         check("fwd_op_flags", {apu_op_o, apu_flags_o}, {core_op_i, core_flags_i});
         if (exp_rv) begin
            check("rdata", core_rdata_o, q[0].data);
            check("rflags", core_rflags_o, q[0].flags);
         end
         if (core_req_i && credit)
            check("apu_id", apu_ID_o, (CORE_ID << SLOT_W) | (issue_cnt % DEPTH));
      end
   end

   task automatic idle();
      core_req_i      = 1'b0;
      apu_gnt_i       = 1'b0;
      apu_rvalid_i    = 1'b0;
      apu_rID_i       = '0;
      apu_rdata_i     = '0;
      apu_rflags_i    = '0;
      core_operands_i = {$urandom, $urandom};
      core_op_i       = OPCODE_WIDTH'($urandom);
      core_flags_i    = FLAGS_IN_WIDTH'($urandom);
   endtask

   task automatic idle_cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         idle();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      check("rst_busy", busy_o, 0);
      check("rst_rvalid", core_rvalid_o, 0);
      check("rst_perr", protocol_err_o, 0);
      check("rst_gnt", core_gnt_o, 0);
      check("rst_req", apu_req_o, 0);
   endtask

   task automatic issue(input logic [ID_WIDTH-1:0] exp_tag);
      @(negedge clk);
      idle();
      core_req_i = 1'b1;
      apu_gnt_i  = 1'b1;
      #2;
      check("issue_gnt", core_gnt_o, 1);
      check("issue_tag", apu_ID_o, exp_tag);
   endtask

   task automatic resp(input logic [ID_WIDTH-1:0] tag, input logic [31:0] d,
                       input logic [4:0] f);
      @(negedge clk);
      idle();
      apu_rvalid_i = 1'b1;
      apu_rID_i    = tag;
      apu_rdata_i  = d;
      apu_rflags_i = f;
      #2;
   endtask

   initial begin
      // 1: single op, response three cycles after issue
      do_reset();
      core_rready_i = 1'b1;
      issue(9'd0);
      idle_cyc(2);
      resp(9'd0, 32'h3F80_0000, 5'd0);
      check("t1_rvalid_early", core_rvalid_o, 0);
      check("t1_busy", busy_o, 1);
      @(negedge clk); idle(); #2;
      check("t1_rvalid", core_rvalid_o, 1);
      check("t1_rdata", core_rdata_o, 32'h3F80_0000);
      @(negedge clk); idle(); #2;
      check("t1_busy_fall", busy_o, 0);
      check("t1_rvalid_fall", core_rvalid_o, 0);

      // 2: fill all credits, then one retire frees exactly one grant
      do_reset();
      issue(9'd0); issue(9'd1); issue(9'd2); issue(9'd3);
      @(negedge clk); idle(); core_req_i = 1'b1; apu_gnt_i = 1'b1; #2;
      check("t2_full_req", apu_req_o, 0);
      check("t2_full_gnt", core_gnt_o, 0);
      @(negedge clk); idle(); core_req_i = 1'b1; apu_gnt_i = 1'b1;
      apu_rvalid_i = 1'b1; apu_rID_i = 9'd0; apu_rdata_i = 32'hA0A0_0000; #2;
      check("t2_full_gnt2", core_gnt_o, 0);
      @(negedge clk); idle(); core_req_i = 1'b1; apu_gnt_i = 1'b1; #2;
      check("t2_retire_cycle_gnt", core_gnt_o, 0);
      check("t2_retire_rvalid", core_rvalid_o, 1);
      issue(9'd0);
      resp(9'd1, 32'h1, 5'd1); resp(9'd2, 32'h2, 5'd2);
      resp(9'd3, 32'h3, 5'd3); resp(9'd0, 32'h4, 5'd4);
      idle_cyc(6);
      #2;
      check("t2_drained", busy_o, 0);

      // 3: out-of-order completion returned in issue order
      do_reset();
      issue(9'd0); issue(9'd1); issue(9'd2);
      resp(9'd2, 32'hAAAA_AAAA, 5'h0A);
      check("t3_rv0", core_rvalid_o, 0);
      resp(9'd0, 32'hBBBB_BBBB, 5'h0B);
      check("t3_rv1", core_rvalid_o, 0);
      resp(9'd1, 32'hCCCC_CCCC, 5'h0C);
      check("t3_rv_b", core_rvalid_o, 1);
      check("t3_data_b", core_rdata_o, 32'hBBBB_BBBB);
      @(negedge clk); idle(); #2;
      check("t3_data_c", core_rdata_o, 32'hCCCC_CCCC);
      @(negedge clk); idle(); #2;
      check("t3_data_a", core_rdata_o, 32'hAAAA_AAAA);
      check("t3_flags_a", core_rflags_o, 5'h0A);
      @(negedge clk); idle(); #2;
      check("t3_empty", core_rvalid_o, 0);

      // 4: core backpressure while all responses land
      do_reset();
      core_rready_i = 1'b0;
      issue(9'd0); issue(9'd1); issue(9'd2); issue(9'd3);
      resp(9'd3, 32'hD3D3_D3D3, 5'd3);
      resp(9'd1, 32'hD1D1_D1D1, 5'd1);
      resp(9'd0, 32'hD0D0_D0D0, 5'd0);
      check("t4_rv_pre", core_rvalid_o, 0);
      resp(9'd2, 32'hD2D2_D2D2, 5'd2);
      for (int i = 0; i < 7; i++) begin
         check("t4_hold_rv", core_rvalid_o, 1);
         check("t4_hold_data", core_rdata_o, 32'hD0D0_D0D0);
         check("t4_rready", apu_rready_o, 1);
         @(negedge clk); idle(); #2;
      end
      core_rready_i = 1'b1;
      check("t4_d0", core_rdata_o, 32'hD0D0_D0D0);
      @(negedge clk); idle(); #2;
      check("t4_d1", core_rdata_o, 32'hD1D1_D1D1);
      @(negedge clk); idle(); #2;
      check("t4_d2", core_rdata_o, 32'hD2D2_D2D2);
      @(negedge clk); idle(); #2;
      check("t4_d3", core_rdata_o, 32'hD3D3_D3D3);
      @(negedge clk); idle(); #2;
      check("t4_empty", core_rvalid_o, 0);

      // 5: foreign tag and duplicate response are dropped, error is sticky
      do_reset();
      core_rready_i = 1'b0;
      issue(9'd0);
      resp(9'd0, 32'h1111_2222, 5'h03);
      resp(9'h004, 32'hDEAD_BEEF, 5'h1F);
      check("t5_perr_pre", protocol_err_o, 0);
      resp(9'd0, 32'h5555_6666, 5'h11);
      check("t5_perr_foreign", protocol_err_o, 1);
      @(negedge clk); idle(); #2;
      check("t5_perr_dup", protocol_err_o, 1);
      check("t5_data_kept", core_rdata_o, 32'h1111_2222);
      check("t5_flags_kept", core_rflags_o, 5'h03);
      core_rready_i = 1'b1;
      @(negedge clk); idle(); #2;
      check("t5_perr_sticky", protocol_err_o, 1);
      check("t5_busy", busy_o, 0);

      // 6: reset with ops in flight, then a late response
      do_reset();
      issue(9'd0); issue(9'd1); issue(9'd2);
      @(negedge clk); idle(); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1; #2;
      check("t6_busy", busy_o, 0);
      check("t6_rvalid", core_rvalid_o, 0);
      check("t6_perr", protocol_err_o, 0);
      resp(9'd1, 32'h7777_7777, 5'd7);
      check("t6_perr_pre", protocol_err_o, 0);
      issue(9'd0);
      check("t6_perr_late", protocol_err_o, 1);
      resp(9'd0, 32'h8888_8888, 5'd8);
      idle_cyc(3);
      #2;
      check("t6_busy_end", busy_o, 0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
